// File: rtl/esc_pwm_decoder.sv
// ESC PWM receive decoder: measures synced pulse high time and recovers the 11-bit speed.
// Optional glitch filter on the synced input: define ESC_PWM_GLITCH_FILT_EN.
module esc_pwm_decoder #(
    parameter int OFFSET  = 6250,
    parameter int SCALE   = 3,
    parameter int TIMEOUT = 2097152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm,
    output logic [10:0] spd,
    output logic        vld,
    output logic        err_short,
    output logic        ovr,
    output logic        lost
);

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        OFST,
        SCAL,
        DONE
    } state_t;

    localparam logic [19:0] OFS_END = 20'(OFFSET - 1);
    localparam logic [1:0]  SCL_END = 2'(SCALE - 1);
    localparam logic [21:0] TO_END  = 22'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic        s1;
    logic        s2;
    logic        lvl;
    logic        lvl_d;
    logic        rise;
    logic        fall;
    logic [19:0] hi_cnt;
    logic [1:0]  scl_cnt;
    logic [11:0] acc;
    logic [21:0] to_cnt;
    logic        start;
    logic        short_p;
    logic        done;
    logic        tick;

    // Sync flops reset high so a line that is already high never looks like a fresh rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= pwm;
            s2 <= s1;
        end
    end

`ifdef ESC_PWM_GLITCH_FILT_EN
    logic [1:0] hist;
    logic       filt;

    always_comb begin
        lvl = filt;
        if (s2 && (&hist))
            lvl = 1'b1;
        else if (!s2 && !(|hist))
            lvl = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
            filt <= 1'b1;
        end else begin
            hist <= {hist[0], s2};
            filt <= lvl;
        end
    end
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lvl_d <= 1'b1;
        else
            lvl_d <= lvl;
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WAIT_LOW;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_LOW: if (!lvl) state_nx = IDLE;
            IDLE:     if (rise) state_nx = OFST;
            OFST: begin
                if (fall)
                    state_nx = (hi_cnt == OFS_END) ? DONE : IDLE;
                else if (hi_cnt == OFS_END)
                    state_nx = SCAL;
            end
            SCAL:     if (fall) state_nx = DONE;
            DONE:     state_nx = rise ? OFST : IDLE;
            default:  state_nx = WAIT_LOW;
        endcase
    end

    always_comb begin
        start   = rise && (state == IDLE || state == DONE);
        short_p = (state == OFST) && fall && (hi_cnt != OFS_END);
        done    = (state == DONE);
        tick    = (state == SCAL);
    end

    // The falling-edge cycle still ticks so exactly H-OFFSET cycles are scaled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt  <= '0;
            scl_cnt <= '0;
            acc     <= '0;
        end else if (start) begin
            hi_cnt  <= '0;
            scl_cnt <= '0;
            acc     <= '0;
        end else if (state == OFST) begin
            hi_cnt <= hi_cnt + 20'd1;
        end else if (tick) begin
            if (scl_cnt == SCL_END) begin
                scl_cnt <= '0;
                if (!acc[11])
                    acc <= acc + 12'd1;
            end else begin
                scl_cnt <= scl_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spd       <= '0;
            vld       <= 1'b0;
            ovr       <= 1'b0;
            err_short <= 1'b0;
            lost      <= 1'b0;
            to_cnt    <= '0;
        end else begin
            vld       <= done;
            ovr       <= done && acc[11];
            err_short <= short_p;
            if (done) begin
                spd    <= acc[11] ? 11'h7ff : acc[10:0];
                lost   <= 1'b0;
                to_cnt <= '0;
            end else begin
                if (!(&to_cnt))
                    to_cnt <= to_cnt + 22'd1;
                if (to_cnt == TO_END) begin
                    lost <= 1'b1;
                    spd  <= '0;
                end
            end
        end
    end

endmodule
